// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern-recognition path.
//   ser_state_e     : serializer FSM state encoding (IDLE, SHIFT).
//   SERIAL_IDLE_BIT : default fill value on the serial line while idle,
//                     shared with the detector bench.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic SERIAL_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the serial pattern-recognition path.
// Accepts a WIDTH-bit word over valid/ready and shifts it out one bit per
// clock on seq_out, gapless across back-to-back words.
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   load_data  : word to serialize (sampled only on accept)
//   load_valid : producer has a word on load_data
//   load_ready : block can accept a word this cycle (from state only)
//   seq_out    : registered serial bit to the detector
//   seq_valid  : registered, seq_out carries a data bit
//   busy       : a word is being shifted
//   done       : one-cycle pulse with the last bit of a word on seq_out
module bit_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = SERIAL_IDLE_BIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seq_out_q, seq_out_d;
  logic             seq_valid_q, seq_valid_d;
  logic             done_q, done_d;

  logic last_bit;
  logic accept;

  // The bit presented on seq_out is registered one step ahead, so the shift
  // register holds only the bits not yet driven: on load the first bit goes
  // straight from load_data to seq_out and the remainder is stored pre-shifted.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    seq_out_d   = IDLE_BIT;
    seq_valid_d = 1'b0;
    done_d      = 1'b0;

    last_bit   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    load_ready = (state_q == IDLE) || last_bit;
    accept     = load_valid && load_ready;

    if (accept) begin
      // Also covers the last-bit cycle: reload takes priority over IDLE.
      state_d     = SHIFT;
      cnt_d       = '0;
      seq_valid_d = 1'b1;
      if (MSB_FIRST) begin
        seq_out_d = load_data[WIDTH-1];
        shreg_d   = load_data << 1;
      end else begin
        seq_out_d = load_data[0];
        shreg_d   = load_data >> 1;
      end
    end else if (state_q == SHIFT && !last_bit) begin
      cnt_d       = cnt_q + 1'b1;
      seq_valid_d = 1'b1;
      done_d      = (cnt_d == CNT_LAST);
      if (MSB_FIRST) begin
        seq_out_d = shreg_q[WIDTH-1];
        shreg_d   = shreg_q << 1;
      end else begin
        seq_out_d = shreg_q[0];
        shreg_d   = shreg_q >> 1;
      end
    end else if (last_bit) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      seq_out_q   <= IDLE_BIT;
      seq_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
      done_q      <= done_d;
    end
  end

  assign seq_out   = seq_out_q;
  assign seq_valid = seq_valid_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // DUT A: WIDTH=8, MSB first
  logic [7:0] a_data;
  logic       a_valid, a_ready, a_seq_out, a_seq_valid, a_busy, a_done;
  // DUT B: WIDTH=4, LSB first
  logic [3:0] b_data;
  logic       b_valid, b_ready, b_seq_out, b_seq_valid, b_busy, b_done;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
    .clock(clock), .reset(reset), .load_data(a_data), .load_valid(a_valid),
    .load_ready(a_ready), .seq_out(a_seq_out), .seq_valid(a_seq_valid),
    .busy(a_busy), .done(a_done));

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_b (
    .clock(clock), .reset(reset), .load_data(b_data), .load_valid(b_valid),
    .load_ready(b_ready), .seq_out(b_seq_out), .seq_valid(b_seq_valid),
    .busy(b_busy), .done(b_done));

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboards: each entry is {expected bit, expected done}
  logic [1:0] qa[$];
  logic [1:0] qb[$];

  bit   mon_en = 1'b0;
  int   a_vcnt, a_dcnt, a_runs, pat_cnt;
  logic a_prev_valid = 1'b0;
  logic [3:0] hist = '0;

  always @(negedge clock) begin
    if (mon_en) begin
      logic [1:0] e;
      // Reference 1100 detector watching every bit, idle fill included
      hist = {hist[2:0], a_seq_out};
      if (hist == 4'b1100) pat_cnt++;
      if (a_seq_valid && !a_prev_valid) a_runs++;
      a_prev_valid = a_seq_valid;
      if (a_seq_valid) begin
        a_vcnt++;
        if (a_done) a_dcnt++;
        if (qa.size() == 0) chk("a_unexpected_bit", 32'd1, 32'd0);
        else begin
          e = qa.pop_front();
          chk("a_bit", {31'd0, a_seq_out}, {31'd0, e[1]});
          chk("a_done", {31'd0, a_done}, {31'd0, e[0]});
        end
      end else begin
        chk("a_idle_out", {31'd0, a_seq_out}, 32'd0);
        chk("a_idle_done", {31'd0, a_done}, 32'd0);
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      logic [1:0] e;
      if (b_seq_valid) begin
        if (qb.size() == 0) chk("b_unexpected_bit", 32'd1, 32'd0);
        else begin
          e = qb.pop_front();
          chk("b_bit", {31'd0, b_seq_out}, {31'd0, e[1]});
          chk("b_done", {31'd0, b_done}, {31'd0, e[0]});
        end
      end else begin
        chk("b_idle_out", {31'd0, b_seq_out}, 32'd0);
        chk("b_idle_done", {31'd0, b_done}, 32'd0);
      end
    end
  end

  // Present a word, push its expected bits, wait for acceptance.
  // waits = number of cycles load_ready was observed low.
  task automatic send_a(input logic [7:0] w, output int waits);
    a_data  = w;
    a_valid = 1'b1;
    for (int i = 0; i < 8; i++) qa.push_back({w[7-i], (i == 7)});
    waits = 0;
    forever begin
      @(negedge clock);
      if (a_ready) break;
      waits++;
      if (waits >= 40) begin
        chk("a_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clock); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] w);
    int waits;
    b_data  = w;
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) qb.push_back({w[i], (i == 3)});
    waits = 0;
    forever begin
      @(negedge clock);
      if (b_ready) break;
      waits++;
      if (waits >= 40) begin
        chk("b_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clock); #1;
    b_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) chk(tag, 32'd0, 32'd1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int w;
    int dsave;
    reset   = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'hC3;
    b_valid = 1'b1;
    b_data  = 4'hF;

    // Reset asserted with load_valid high: reset values immediately and while held
    #2;
    chk("rst_seq_out", {31'd0, a_seq_out}, 32'd0);
    chk("rst_seq_valid", {31'd0, a_seq_valid}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_seq_valid", {31'd0, a_seq_valid}, 32'd0);
    chk("rst_hold_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_hold_done", {31'd0, a_done}, 32'd0);
    chk("rst_hold_b_valid", {31'd0, b_seq_valid}, 32'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b0;
    @(posedge clock); #1;
    mon_en = 1'b1;

    // Single word 8'hCC
    repeat (2) @(posedge clock);
    #1;
    a_vcnt = 0; a_dcnt = 0; a_runs = 0; pat_cnt = 0;
    send_a(8'hCC, w);
    chk("single_busy", {31'd0, a_busy}, 32'd1);
    drain("single_drain_timeout");
    chk("single_valid_cycles", a_vcnt, 8);
    chk("single_done_count", a_dcnt, 1);
    chk("single_pattern_1100", pat_cnt, 2);
    chk("single_busy_after", {31'd0, a_busy}, 32'd0);

    // Back-to-back F0 then 0F, gapless
    a_vcnt = 0; a_dcnt = 0; a_runs = 0;
    send_a(8'hF0, w);
    send_a(8'h0F, w);
    chk("b2b_second_wait", w, 7);
    drain("b2b_drain_timeout");
    chk("b2b_valid_cycles", a_vcnt, 16);
    chk("b2b_runs", a_runs, 1);
    chk("b2b_done_count", a_dcnt, 2);

    // Backpressure: AA presented while bit 3 of 8'h55 is on the line
    send_a(8'h55, w);
    repeat (3) @(posedge clock);
    #1;
    send_a(8'hAA, w);
    chk("bp_not_ready_cycles", w, 4);
    drain("bp_drain_timeout");

    // Reset mid-word after bit 4 of 8'hFF
    send_a(8'hFF, w);
    repeat (4) @(posedge clock);
    dsave = a_dcnt;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_seq_valid", {31'd0, a_seq_valid}, 32'd0);
    chk("midrst_done", {31'd0, a_done}, 32'd0);
    chk("midrst_busy", {31'd0, a_busy}, 32'd0);
    chk("midrst_seq_out", {31'd0, a_seq_out}, 32'd0);
    qa.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("midrst_no_done", a_dcnt, dsave);
    send_a(8'h81, w);
    drain("midrst_drain_timeout");

    // LSB-first WIDTH=4
    send_b(4'b0011);
    chk("b_busy", {31'd0, b_busy}, 32'd1);
    drain("b_drain_timeout");
    chk("b_busy_after", {31'd0, b_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
